// File: rtl/uart_echo_tx_pkg.sv
// Shared constants, serializer state encoding and the baud divider helper
// for the UART echo transmitter and its neighbours on the UART link.
package uart_echo_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Clocks per serial bit; integer division, remainder is ignored.
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_echo_tx_if.sv
// Byte-stream input and serial/status outputs of the echo transmitter.
// master = byte producer (uart_rx side), slave = uart_echo_tx.
interface uart_echo_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    in_byte;
  logic          in_valid;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] level;

  modport master (
    output in_byte, in_valid,
    input  tx, busy, overflow, level
  );

  modport slave (
    input  in_byte, in_valid,
    output tx, busy, overflow, level
  );
endinterface

// File: rtl/uart_echo_tx_byte_fifo.sv
// Synchronous byte FIFO. Head is presented combinationally on dout while
// not empty. A push while full is accepted only if a pop happens on the
// same edge; otherwise it is ignored (the caller flags the drop).
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == DEPTH_L);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rptr];
  assign level     = r_level;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); level tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_tx.sv
// UART echo transmitter: buffers received bytes and sends them back as
// 8N1 serial, optionally appending LF after every CR.
//
//  state    | meaning
//  ST_IDLE  | line high, waiting for a pending LF or a FIFO byte
//  ST_START | start bit (low) for DIV clocks
//  ST_DATA  | 8 data bits, LSB first, DIV clocks each
//  ST_STOP  | stop bit (high); last clock chains straight into next frame
module uart_echo_tx
  import uart_echo_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8,
  parameter int CRLF       = 1
) (
  input logic          clk,
  input logic          rstn,
  uart_echo_tx_if.slave bus
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BCNT_LAST = CW'(DIV - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_bcnt, w_bcnt_nxt;
  logic [2:0]    r_bidx, w_bidx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_lf_pend, w_lf_pend_nxt;
  logic          r_is_lf, w_is_lf_nxt;
  logic          r_is_cr, w_is_cr_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_overflow;
  logic          w_pop;
  logic          w_take_fifo;
  logic          w_take_lf;
  logic          w_bit_end;
  logic [7:0]    w_dout;
  logic [LW-1:0] w_level;
  logic          w_full;
  logic          w_empty;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (bus.in_valid),
    .din   (bus.in_byte),
    .pop   (w_pop),
    .dout  (w_dout),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_bit_end    = (r_bcnt == BCNT_LAST);
  assign bus.tx       = r_tx;
  assign bus.overflow = r_overflow;
  assign bus.level    = w_level;
  assign bus.busy     = (r_state != ST_IDLE) | (w_level != '0) | r_lf_pend;

  // Next-state, counters and the value tx will carry after this edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_bcnt_nxt    = r_bcnt;
    w_bidx_nxt    = r_bidx;
    w_shift_nxt   = r_shift;
    w_lf_pend_nxt = r_lf_pend;
    w_is_lf_nxt   = r_is_lf;
    w_is_cr_nxt   = r_is_cr;
    w_take_fifo   = 1'b0;
    w_take_lf     = 1'b0;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (r_lf_pend)     w_take_lf   = 1'b1;
        else if (!w_empty) w_take_fifo = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bcnt_nxt  = '0;
          w_bidx_nxt  = '0;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_bcnt_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bidx == 3'd7) w_state_nxt = ST_STOP;
          else                w_bidx_nxt  = r_bidx + 1'b1;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          // A CR that just finished raises the LF request, which is served
          // on this very clock so nothing can slip between CR and LF.
          if ((CRLF != 0) && r_is_cr && !r_is_lf) begin
            w_lf_pend_nxt = 1'b1;
            w_take_lf     = 1'b1;
          end else if (!w_empty) begin
            w_take_fifo = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_bcnt_nxt  = '0;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_take_lf) begin
      w_shift_nxt   = ASCII_LF;
      w_is_lf_nxt   = 1'b1;
      w_is_cr_nxt   = 1'b0;
      w_lf_pend_nxt = 1'b0;
      w_state_nxt   = ST_START;
      w_bcnt_nxt    = '0;
    end else if (w_take_fifo) begin
      w_pop       = 1'b1;
      w_shift_nxt = w_dout;
      w_is_lf_nxt = 1'b0;
      w_is_cr_nxt = (w_dout == ASCII_CR);
      w_state_nxt = ST_START;
      w_bcnt_nxt  = '0;
    end

    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Serializer state and registered tx pin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_bcnt    <= '0;
      r_bidx    <= '0;
      r_shift   <= '0;
      r_lf_pend <= 1'b0;
      r_is_lf   <= 1'b0;
      r_is_cr   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_bidx    <= w_bidx_nxt;
      r_shift   <= w_shift_nxt;
      r_lf_pend <= w_lf_pend_nxt;
      r_is_lf   <= w_is_lf_nxt;
      r_is_cr   <= w_is_cr_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Sticky drop flag: a push into a full FIFO with no pop on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       r_overflow <= 1'b0;
    else if (bus.in_valid && w_full && !w_pop)       r_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_echo_tx.sv
// Bench for uart_echo_tx: DUT a has CRLF=1, DUT b has CRLF=0 (DIV=12).
// Decoded frames are checked against a scoreboard of expected bytes.
module tb_uart_echo_tx;

  localparam int CLK_FREQ = 1200000;
  localparam int BAUD     = 100000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rst_gen  = 0;
  int   nfr_a = 0;
  int   nfr_b = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int         st_a[$];
  int         st_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo_tx_if #(.FIFO_DEPTH(8)) ifa ();
  uart_echo_tx_if #(.FIFO_DEPTH(8)) ifb ();

  uart_echo_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8), .CRLF(1)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa));
  uart_echo_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8), .CRLF(0)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic txof(input int sel);
    return (sel == 0) ? ifa.tx : ifb.tx;
  endfunction

  function automatic logic busyof(input int sel);
    return (sel == 0) ? ifa.busy : ifb.busy;
  endfunction

  task automatic sb_expect(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      q_a.push_back(b);
      if (b == 8'h0D) q_a.push_back(8'h0A);
    end else begin
      q_b.push_back(b);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] b);
    if (sel == 0) begin ifa.in_valid = v; ifa.in_byte = b; end
    else          begin ifb.in_valid = v; ifb.in_byte = b; end
  endtask

  // Pushes seq on consecutive edges; n_edge = cycle index of the first push edge.
  // Returns on the negedge right after the last push edge, inputs released.
  task automatic push_seq(input int sel, input logic [7:0] seq[$], output int n_edge);
    n_edge = 0;
    @(negedge clk);
    foreach (seq[i]) begin
      drive(sel, 1'b1, seq[i]);
      @(posedge clk);
      #1;
      if (i == 0) n_edge = cyc;
      @(negedge clk);
    end
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int sel, input int budget, output int fall_cyc);
    int k = 0;
    while (busyof(sel) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(k >= budget), 0);
    fall_cyc = cyc;
    repeat (10) @(negedge clk);
    chk("sb_drained", (sel == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rst_gen++;
    q_a.delete();
    q_b.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Frame decoder: detect start on a low sample, then sample each bit mid-way.
  task automatic mon(input int sel);
    logic [7:0] b;
    logic [7:0] exp;
    logic       ok_start;
    logic       ok_stop;
    int         g;
    forever begin
      @(negedge clk);
      if (rstn && txof(sel) == 1'b0) begin
        g = rst_gen;
        if (sel == 0) st_a.push_back(cyc); else st_b.push_back(cyc);
        repeat (6) @(negedge clk);
        ok_start = (txof(sel) == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (12) @(negedge clk);
          b[i] = txof(sel);
        end
        repeat (12) @(negedge clk);
        ok_stop = txof(sel);
        if (g == rst_gen) begin
          chk("start_bit", 32'(ok_start), 1);
          chk("stop_bit", 32'(ok_stop), 1);
          if (sel == 0) begin
            nfr_a++;
            if (q_a.size() == 0) chk("sb_unexpected_frame", {24'h0, b}, 32'h100);
            else begin exp = q_a.pop_front(); chk("frame_byte_a", {24'h0, b}, {24'h0, exp}); end
          end else begin
            nfr_b++;
            if (q_b.size() == 0) chk("sb_unexpected_frame", {24'h0, b}, 32'h100);
            else begin exp = q_b.pop_front(); chk("frame_byte_b", {24'h0, b}, {24'h0, exp}); end
          end
        end
        repeat (5) @(negedge clk);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sq[$];
    int n, fall, f0, lows;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_tx", ifa.tx, 1);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_overflow", ifa.overflow, 0);
    chk("rst_level", ifa.level, 0);
    chk("rst_tx_b", ifb.tx, 1);

    // 1: single 0x55, latency and frame length
    sb_expect(0, 8'h55);
    sq = {8'h55};
    push_seq(0, sq, n);
    chk("t1_level_after_push", ifa.level, 1);
    chk("t1_tx_before_pop", ifa.tx, 1);
    @(negedge clk);
    chk("t1_tx_start", ifa.tx, 0);
    chk("t1_level_after_pop", ifa.level, 0);
    chk("t1_busy", ifa.busy, 1);
    wait_idle(0, 400, fall);
    chk("t1_frame_len", fall - n, 121);

    // 2: CR gets an LF appended back-to-back
    st_a.delete();
    sb_expect(0, 8'h0D);
    sq = {8'h0D};
    push_seq(0, sq, n);
    wait_idle(0, 600, fall);
    chk("t2_total_len", fall - n, 241);
    chk("t2_frames", st_a.size(), 2);
    if (st_a.size() == 2) begin
      chk("t2_first_start", st_a[0] - n, 1);
      chk("t2_gap", st_a[1] - st_a[0], 120);
    end

    // 2b: CRLF=0 sends CR verbatim
    f0 = nfr_b;
    sb_expect(1, 8'h0D);
    push_seq(1, sq, n);
    wait_idle(1, 600, fall);
    chk("t2b_len", fall - n, 121);
    chk("t2b_frames", nfr_b - f0, 1);

    // 3: ten back-to-back pushes, tenth dropped
    f0 = nfr_a;
    sq.delete();
    for (int i = 0; i < 10; i++) sq.push_back(8'(8'h30 + i));
    for (int i = 0; i < 9; i++) sb_expect(0, 8'(8'h30 + i));
    push_seq(0, sq, n);
    chk("t3_level_full", ifa.level, 8);
    chk("t3_overflow", ifa.overflow, 1);
    wait_idle(0, 1400, fall);
    chk("t3_len", fall - n, 1081);
    chk("t3_frames", nfr_a - f0, 9);
    chk("t3_overflow_sticky", ifa.overflow, 1);
    chk("t3_level_empty", ifa.level, 0);
    do_reset();
    chk("t3_overflow_cleared", ifa.overflow, 0);

    // 4: push into a full FIFO on the edge where STOP ends and pops
    sq.delete();
    for (int i = 0; i < 9; i++) sq.push_back(8'(8'h40 + i));
    for (int i = 0; i < 10; i++) sb_expect(0, 8'(8'h40 + i));
    push_seq(0, sq, n);
    chk("t4_level_full", ifa.level, 8);
    chk("t4_overflow_pre", ifa.overflow, 0);
    while (cyc < n + 120) @(negedge clk);
    drive(0, 1'b1, 8'h49);
    @(posedge clk);
    #1;
    chk("t4_level_held", ifa.level, 8);
    chk("t4_overflow_post", ifa.overflow, 0);
    chk("t4_next_start", ifa.tx, 0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    wait_idle(0, 1500, fall);
    chk("t4_len", fall - n, 1201);

    // 5: async reset during data bit 4 with bytes queued
    sq.delete();
    for (int i = 0; i < 4; i++) sq.push_back(8'(8'h61 + i));
    for (int i = 0; i < 4; i++) sb_expect(0, 8'(8'h61 + i));
    push_seq(0, sq, n);
    chk("t5_level", ifa.level, 3);
    while (cyc < n + 66) @(negedge clk);
    chk("t5_tx_bit4", ifa.tx, 0);
    rstn = 1'b0;
    rst_gen++;
    q_a.delete();
    #1;
    chk("t5_tx_async", ifa.tx, 1);
    chk("t5_busy_async", ifa.busy, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    lows = 0;
    repeat (130) begin
      @(negedge clk);
      if (!ifa.tx) lows++;
    end
    chk("t5_quiet", lows, 0);
    chk("t5_level", ifa.level, 0);
    chk("t5_busy", ifa.busy, 0);
    chk("t5_overflow", ifa.overflow, 0);
    f0 = nfr_a;
    sb_expect(0, 8'h41);
    sq = {8'h41};
    push_seq(0, sq, n);
    wait_idle(0, 400, fall);
    chk("t5_post_len", fall - n, 121);
    chk("t5_post_frames", nfr_a - f0, 1);

    // 6: CR then '1' back-to-back -> CR, LF, '1' with no gaps
    st_a.delete();
    sb_expect(0, 8'h0D);
    sb_expect(0, 8'h31);
    sq = {8'h0D, 8'h31};
    push_seq(0, sq, n);
    wait_idle(0, 800, fall);
    chk("t6_len", fall - n, 361);
    chk("t6_frames", st_a.size(), 3);
    if (st_a.size() == 3) begin
      chk("t6_gap1", st_a[1] - st_a[0], 120);
      chk("t6_gap2", st_a[2] - st_a[1], 120);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
